// File: rtl/instr_loader.sv
// Byte-stream program loader for instr_ram: count header plus 3-byte LE words.
// Holds the core in reset until a complete, valid program has been written.
module instr_loader #(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 21
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               ram_write_en,
   output logic [ADDR_W-1:0]  ram_write_addr,
   output logic [INSTR_W-1:0] ram_write_data,
   output logic               core_reset,
   output logic               load_busy,
   output logic               load_done,
   output logic               load_error
);

   localparam int         HI_W   = INSTR_W - 16;
   localparam logic [8:0] MAX_N  = 9'(2 ** ADDR_W);
   localparam logic [7:0] B2_BAD = 8'(8'hFF << HI_W);

   typedef enum logic [2:0] {
      IDLE, B0, B1, B2, WRITE, DONE, ERROR
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] last;
   logic [7:0]        b0, b1;
   logic              accept;
   logic              hdr_ok;
   logic              b2_ok;

   assign accept = in_valid && in_ready;
   assign hdr_ok = (in_data != 8'd0) && ({1'b0, in_data} <= MAX_N);
   assign b2_ok  = (in_data & B2_BAD) == 8'h00;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept) state_nxt = hdr_ok ? B0 : ERROR;
         B0:    if (accept) state_nxt = B1;
         B1:    if (accept) state_nxt = B2;
         B2:    if (accept) state_nxt = b2_ok ? WRITE : ERROR;
         WRITE: state_nxt = (index == last) ? DONE : B0;
         DONE:  state_nxt = IDLE;
         ERROR: state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // Outputs are decoded from the next state so every one is a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         in_ready       <= 1'b1;
         ram_write_en   <= 1'b0;
         ram_write_addr <= '0;
         ram_write_data <= '0;
         core_reset     <= 1'b1;
         load_busy      <= 1'b0;
         load_done      <= 1'b0;
         load_error     <= 1'b0;
         index          <= '0;
         last           <= '0;
         b0             <= '0;
         b1             <= '0;
      end else begin
         state        <= state_nxt;
         in_ready     <= state_nxt inside {IDLE, B0, B1, B2};
         ram_write_en <= state_nxt == WRITE;
         load_busy    <= !(state_nxt inside {IDLE, ERROR});
         load_done    <= state_nxt == DONE;
         load_error   <= state_nxt == ERROR;

         if (state_nxt inside {B0, B1, B2, WRITE, DONE, ERROR})
            core_reset <= 1'b1;
         else if (state == DONE)
            core_reset <= 1'b0;

         if (!abort) begin
            if (accept) begin
               unique case (state)
                  IDLE: begin
                     index <= '0;
                     last  <= ADDR_W'(in_data - 8'd1);
                  end
                  B0: b0 <= in_data;
                  B1: b1 <= in_data;
                  B2: if (b2_ok) begin
                     ram_write_addr <= index;
                     ram_write_data <= {in_data[HI_W-1:0], b1, b0};
                  end
                  default: ;
               endcase
            end
            if (state == WRITE && index != last)
               index <= index + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stream-level parser model plus a
// per-cycle compare process on the RAM write port and status outputs.
module tb_instr_loader;

   typedef logic [7:0] u8;
   typedef struct {
      int          addr;
      logic [20:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        ram_write_en;
   logic [4:0]  ram_write_addr;
   logic [20:0] ram_write_data;
   logic        core_reset;
   logic        load_busy;
   logic        load_done;
   logic        load_error;

   instr_loader #(.ADDR_W(5), .INSTR_W(21)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .abort          (abort),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .ram_write_en   (ram_write_en),
      .ram_write_addr (ram_write_addr),
      .ram_write_data (ram_write_data),
      .core_reset     (core_reset),
      .load_busy      (load_busy),
      .load_done      (load_done),
      .load_error     (load_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int cr_fall_cyc = -1;
   int exp_ok;
   int exp_err;
   logic prev_cr = 1'b1;
   logic prev_done = 1'b0;

   u8           stim[$];
   wr_t         exp_q[$];
   wr_t         wr_log[$];
   logic [20:0] mem[32];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   // Stream-level model: what a correct loader writes for the bytes in stim.
   function automatic void model();
      int n;
      logic [23:0] w;
      exp_ok = 0;
      exp_err = 0;
      exp_q.delete();
      n = int'(stim[0]);
      if (n < 1 || n > 32) begin
         exp_err = 1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (stim.size() < 4 + 3 * i) return;
         if (stim[3 + 3 * i] > 8'h1F) begin
            exp_err = 1;
            return;
         end
         w = 24'(stim[1 + 3 * i])
           + 24'(stim[2 + 3 * i]) * 24'd256
           + 24'(stim[3 + 3 * i]) * 24'd65536;
         exp_q.push_back('{addr: i, data: 21'(w), cyc: 0});
      end
      exp_ok = 1;
   endfunction

   function automatic void add_word(input logic [23:0] w);
      stim.push_back(w[7:0]);
      stim.push_back(w[15:8]);
      stim.push_back(w[23:16]);
   endfunction

   task automatic send(input u8 b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: byte 0x%0h not taken in 40 cycles", b);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic run(input int gapmax, input int hdr_cr);
      int d0;
      d0 = done_cnt;
      model();
      for (int i = 0; i < stim.size(); i++) begin
         if (gapmax > 0)
            repeat ($urandom_range(gapmax, 0)) @(negedge clk);
         send(stim[i]);
         if (i == 0 && hdr_cr != 0)
            chk("core_reset_after_hdr", 32'(core_reset), 1);
      end
      repeat (4) @(negedge clk);
      chk("writes_pending", exp_q.size(), 0);
      chk("done_pulses", done_cnt - d0, exp_ok);
      chk("load_error", 32'(load_error), exp_err);
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_error", 32'(load_error), 0);
      chk("abort_core_reset", 32'(core_reset), 1);
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_busy", 32'(load_busy), 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_we", 32'(ram_write_en), 0);
      chk("rst_addr", 32'(ram_write_addr), 0);
      chk("rst_data", 32'(ram_write_data), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_busy", 32'(load_busy), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_error", 32'(load_error), 0);
   endtask

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (ram_write_en) begin
               wr_log.push_back('{addr: int'(ram_write_addr),
                                  data: ram_write_data, cyc: cyc});
               mem[ram_write_addr] = ram_write_data;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %0d data 0x%0h, required none",
                           ram_write_addr, ram_write_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", 32'(ram_write_addr), e.addr);
                  chk("wr_data", 32'(ram_write_data), 32'(e.data));
               end
               chk("we_in_ready", 32'(in_ready), 0);
            end
            if (load_done) begin
               done_cnt++;
               done_cyc = cyc;
               chk("done_excl_we", 32'(ram_write_en), 0);
               chk("done_core_reset", 32'(core_reset), 1);
            end
            if (load_error) begin
               chk("err_in_ready", 32'(in_ready), 0);
               chk("err_busy", 32'(load_busy), 0);
               chk("err_core_reset", 32'(core_reset), 1);
            end
            if (prev_done)
               chk("core_reset_after_done", 32'(core_reset), 0);
            if (prev_cr && !core_reset)
               cr_fall_cyc = cyc;
            prev_done = load_done;
            prev_cr   = core_reset;
         end else begin
            prev_done = 1'b0;
            prev_cr   = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, l1, l2;
      reset_n  = 1'b1;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1 reset_n = 1'b0;
      #2;
      check_reset_vals();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // N = 3, back-to-back bytes, timing pinned by hand
      l0 = wr_log.size();
      stim.delete();
      stim.push_back(8'd3);
      add_word(24'h000001);
      add_word(24'h1ABCDE);
      add_word(24'h1FFFFF);
      run(0, 0);
      chk("t1_writes", wr_log.size() - l0, 3);
      if (wr_log.size() >= l0 + 3) begin
         chk("t1_a0", wr_log[l0].addr, 0);
         chk("t1_d0", 32'(wr_log[l0].data), 32'h000001);
         chk("t1_a1", wr_log[l0 + 1].addr, 1);
         chk("t1_d1", 32'(wr_log[l0 + 1].data), 32'h1ABCDE);
         chk("t1_a2", wr_log[l0 + 2].addr, 2);
         chk("t1_d2", 32'(wr_log[l0 + 2].data), 32'h1FFFFF);
         chk("t1_gap01", wr_log[l0 + 1].cyc - wr_log[l0].cyc, 4);
         chk("t1_gap12", wr_log[l0 + 2].cyc - wr_log[l0 + 1].cyc, 4);
         chk("t1_done_lat", done_cyc - wr_log[l0 + 2].cyc, 1);
         chk("t1_cr_lat", cr_fall_cyc - wr_log[l0 + 2].cyc, 2);
      end
      chk("t1_core_reset", 32'(core_reset), 0);

      // N = 32 reload, data = addr * 0x010101
      for (int i = 0; i < 32; i++) mem[i] = '1;
      l0 = wr_log.size();
      stim.delete();
      stim.push_back(8'd32);
      for (int i = 0; i < 32; i++) add_word(24'(i * 32'h010101));
      run(0, 1);
      chk("t2_writes", wr_log.size() - l0, 32);
      for (int i = 0; i < 32; i++)
         chk("t2_mem", 32'(mem[i]), 32'(i * 32'h010101));
      chk("t2_core_reset", 32'(core_reset), 0);

      // Bad headers
      stim.delete();
      stim.push_back(8'h00);
      run(0, 0);
      chk("hdr0_in_ready", 32'(in_ready), 0);
      do_abort();
      stim.delete();
      stim.push_back(8'h21);
      run(0, 0);
      chk("hdr21_in_ready", 32'(in_ready), 0);
      do_abort();

      // Bad b2 in word 1
      l0 = wr_log.size();
      stim.delete();
      stim.push_back(8'd2);
      add_word(24'h0A0B0C);
      add_word(24'h202211);
      run(0, 0);
      chk("t5_writes", wr_log.size() - l0, 1);
      chk("t5_core_reset", 32'(core_reset), 1);
      do_abort();

      // N = 5 gap-free then with random gaps
      stim.delete();
      stim.push_back(8'd5);
      add_word(24'h010203);
      add_word(24'h1F00FF);
      add_word(24'h000100);
      add_word(24'h155555);
      add_word(24'h0AAAAA);
      l0 = wr_log.size();
      run(0, 1);
      l1 = wr_log.size();
      run(7, 1);
      l2 = wr_log.size();
      chk("t6_nogap_writes", l1 - l0, 5);
      chk("t6_gap_writes", l2 - l1, 5);

      // Reset mid-load after the 2nd word of N = 4
      stim.delete();
      stim.push_back(8'd4);
      add_word(24'h001111);
      add_word(24'h002222);
      run(0, 1);
      chk("t7_busy", 32'(load_busy), 1);
      reset_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      l0 = wr_log.size();
      stim.delete();
      stim.push_back(8'd1);
      add_word(24'h012345);
      run(0, 1);
      chk("t7_writes", wr_log.size() - l0, 1);
      chk("t7_core_reset", 32'(core_reset), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that drives the instruction RAM's write port (`write_en`/`write_addr`/`write_data`) from a byte stream, e.g. a UART receiver. It parses a count header and little-endian 3-byte instruction words, writes them to consecutive RAM addresses from 0, and holds the execution core in reset until a complete, valid program has been written. It sits between the host link and `instr_ram`, and lets hardware load programs at runtime instead of only from a preloaded memory file.

## Interface
- `ADDR_W`, 5, RAM address width; max program length is 2^ADDR_W = 32.
- `INSTR_W`, 21, instruction width; must satisfy 17 ≤ INSTR_W ≤ 24.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `abort`  in  1  synchronous; returns the FSM to IDLE from any state.
- `in_valid`  in  1  a stream byte is present.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `ram_write_en`  out  1  write strobe to `instr_ram`.
- `ram_write_addr`  out  ADDR_W  write address.
- `ram_write_data`  out  INSTR_W  instruction word.
- `core_reset`  out  1  active-high reset to the core and the PC in `instr_ram`.
- `load_busy`  out  1  high in every state except IDLE and ERROR.
- `load_done`  out  1  one-cycle pulse on successful completion.
- `load_error`  out  1  high while in ERROR.

## Operation
- Stream format: header byte N, then N words of 3 bytes each (b0 = bits 7:0, b1 = bits 15:8, b2 = bits 23:16, of which bits INSTR_W-1:16 are used).
- Valid N is 1..32. N = 0 or N > 32 → ERROR.
- In b2, the bits above INSTR_W-17 must be zero, otherwise → ERROR; the word with the bad b2 is not written.
- FSM states: IDLE, B0, B1, B2, WRITE, DONE, ERROR.
- IDLE: `in_ready` = 1. A valid header → B0, with index = 0 and count = N.
- B0, B1, B2: `in_ready` = 1. Each accepted byte is stored and the FSM advances; an accepted b2 → WRITE.
- WRITE: `in_ready` = 0, `ram_write_en` = 1, address = index, data = assembled word.
  - If index = count−1 → DONE.
  - Otherwise index + 1 → B0.
- DONE: `in_ready` = 0, `load_done` = 1 → IDLE.
- ERROR: `in_ready` = 0. Stays in ERROR until `abort`, which → IDLE.
- `abort` has priority over all other transitions. A partial load leaves `core_reset` = 1.
- All outputs are registered.
- `ram_write_addr` and `ram_write_data` hold their last values when `ram_write_en` = 0.

## Timing
- Reset values: FSM = IDLE, `in_ready` = 1, `ram_write_en` = 0, `ram_write_addr` = 0, `ram_write_data` = 0, `core_reset` = 1, `load_busy` = 0, `load_done` = 0, `load_error` = 0, index = 0.
- `core_reset`:
  - Goes high the cycle after a valid header is accepted.
  - Stays high through DONE.
  - Goes low in the first IDLE cycle after DONE.
  - Also high in ERROR, after `abort` from a partial load, and from reset until the first successful load.
- Latency: b2 accepted at edge k → `ram_write_en` high in cycle k+1 → next byte can be accepted at edge k+2.
- Throughput: best case is 4 cycles per instruction.
- Last write in cycle w → `load_done` high in cycle w+1 → `core_reset` low in cycle w+2.
- Stalls: `in_valid` may drop between any bytes with no timeout; the FSM waits indefinitely.
- Reset asserted mid-load: immediate return to reset values. RAM contents are undefined (partial), and `core_reset` = 1 protects the core.
- A new header in IDLE after a successful load starts a reload and reasserts `core_reset`. `load_done` never coincides with `ram_write_en`.

## Test plan
- Load N = 3, words 0x000001, 0x1ABCDE, 0x1FFFFF with `in_valid` held high:
  - Expect writes addr 0/1/2 with exactly those data, each write 4 cycles apart.
  - Expect `load_done` pulse 1 cycle after the last write, then `core_reset` falling 1 cycle later.
- Full load N = 32 with data = address × 0x010101:
  - Expect 32 writes, addr 0..31 with no wrap.
  - Read back through `instr_ram` and match all 32 words.
- Header 0x00, and separately header 0x21:
  - Expect ERROR, `load_error` = 1, `in_ready` = 0, no write.
  - `abort` → IDLE with `load_error` = 0, `core_reset` = 1.
- N = 2 where word 1 b2 = 0x20:
  - Expect the addr 0 write only, then ERROR.
  - `core_reset` stays 1 and `load_done` never pulses.
- Random `in_valid` gaps (0–7 idle cycles) on an N = 5 load: same writes as the gap-free run, no byte lost or duplicated.
- `reset_n` low for 1 cycle after the 2nd word of N = 4:
  - All outputs return to reset values asynchronously.
  - A following clean N = 1 load writes addr 0 and completes normally.
